// File: rtl/nn_pkg.sv
// Shared definitions for the inference accelerator: network dimensions,
// pixel width and the frame loader state encoding.
package nn_pkg;

    localparam int INPUT_SIZE  = 784;
    localparam int HIDDEN_SIZE = 64;
    localparam int OUTPUT_SIZE = 10;
    localparam int PIXEL_W     = 8;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FIRE  = 2'd2,
        ST_WAIT  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/nn_frame_loader_if.sv
// Byte-wide valid/ready pixel stream with an end-of-frame marker.
interface nn_frame_loader_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/nn_frame_buffer.sv
// Register file holding one frame: single indexed write port, every
// entry visible at once on a flattened read bus.
module nn_frame_buffer #(
    parameter int DEPTH  = 784,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [DATA_W-1:0]         wr_data,
    output logic [DEPTH*DATA_W-1:0]   rd_flat
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_pix
        logic [DATA_W-1:0] pix_r;

        // One pixel register, loaded when the write index selects it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pix_r <= '0;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                pix_r <= wr_data;
            end
        end

        assign rd_flat[i*DATA_W +: DATA_W] = pix_r;
    end

endmodule

// File: rtl/nn_frame_loader.sv
// Assembles a pixel stream into a full frame, starts the accelerator and
// holds the frame until it reports done; malformed frames are flagged.
module nn_frame_loader
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = nn_pkg::INPUT_SIZE,
    parameter int DATA_W     = nn_pkg::PIXEL_W,
    parameter int IDX_W      = 10,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nn_frame_loader_if.slave             s,
    output logic [INPUT_SIZE*DATA_W-1:0] frame_data,
    output logic                         nn_start,
    input  logic                         nn_done,
    output logic                         busy,
    output logic                         err_short,
    output logic                         err_long,
    output logic [CNT_W-1:0]             frame_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    loader_state_e     state_r, state_s;
    logic [IDX_W-1:0]  wr_idx_r, wr_idx_s;
    logic              beat_s;
    logic              wr_en_s;
    logic              err_short_s;
    logic              err_long_s;
    logic              cnt_inc_s;
    logic              s_ready_r;
    logic              nn_start_r;
    logic              busy_r;
    logic              err_short_r;
    logic              err_long_r;
    logic [CNT_W-1:0]  frame_count_r;

    // Next-state, write-index and event decode
    always_comb begin
        state_s     = state_r;
        wr_idx_s    = wr_idx_r;
        wr_en_s     = 1'b0;
        err_short_s = 1'b0;
        err_long_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        beat_s      = s.s_valid && s_ready_r;
        case (state_r)
            ST_FILL: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (wr_idx_r == LAST_IDX) begin
                        wr_idx_s = '0;
                        if (s.s_last) begin
                            state_s = ST_FIRE;
                        end else begin
                            err_long_s = 1'b1;
                            state_s    = ST_DRAIN;
                        end
                    end else if (s.s_last) begin
                        err_short_s = 1'b1;
                        wr_idx_s    = '0;
                    end else begin
                        wr_idx_s = wr_idx_r + IDX_W'(1);
                    end
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (beat_s && s.s_last) begin
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIRE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (nn_done) begin
                    cnt_inc_s = 1'b1;
                    state_s   = ST_FILL;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s  = ST_FILL;
                wr_idx_s = '0;
            end
        endcase
    end

    // State, index and registered outputs; outputs are decoded from the
    // next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_FILL;
            wr_idx_r      <= '0;
            s_ready_r     <= 1'b0;
            nn_start_r    <= 1'b0;
            busy_r        <= 1'b0;
            err_short_r   <= 1'b0;
            err_long_r    <= 1'b0;
            frame_count_r <= '0;
        end else begin
            state_r     <= state_s;
            wr_idx_r    <= wr_idx_s;
            s_ready_r   <= (state_s == ST_FILL) || (state_s == ST_DRAIN);
            nn_start_r  <= (state_s == ST_FIRE);
            busy_r      <= (state_s == ST_FIRE) || (state_s == ST_WAIT) ||
                           ((state_s == ST_FILL) && (wr_idx_s != '0));
            err_short_r <= err_short_s;
            err_long_r  <= err_long_s;
            if (cnt_inc_s) begin
                frame_count_r <= frame_count_r + CNT_W'(1);
            end
        end
    end

    nn_frame_buffer #(
        .DEPTH  (INPUT_SIZE),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_s),
        .wr_idx  (wr_idx_r),
        .wr_data (s.s_data),
        .rd_flat (frame_data)
    );

    assign s.s_ready   = s_ready_r;
    assign nn_start    = nn_start_r;
    assign busy        = busy_r;
    assign err_short   = err_short_r;
    assign err_long    = err_long_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Bench for nn_frame_loader: cycle table on a 4-pixel instance, random
// gapped 784-pixel frames against golden images, and async reset cases.
module tb_nn_frame_loader;
    import nn_pkg::*;

    localparam int BIG = 784;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nn_frame_loader_if #(.DATA_W(8)) sif4 ();
    nn_frame_loader_if #(.DATA_W(8)) sifb ();

    logic [31:0]        fd4;
    logic               st4, dn4, bz4, es4, el4;
    logic [15:0]        fc4;
    logic [BIG*8-1:0]   fdb;
    logic               stb, dnb, bzb, esb, elb;
    logic [15:0]        fcb;

    nn_frame_loader #(.INPUT_SIZE(4), .DATA_W(8), .IDX_W(10), .CNT_W(16)) u_small (
        .clk(clk), .rst_n(rst_n), .s(sif4.slave), .frame_data(fd4), .nn_start(st4),
        .nn_done(dn4), .busy(bz4), .err_short(es4), .err_long(el4), .frame_count(fc4)
    );

    nn_frame_loader #(.INPUT_SIZE(BIG), .DATA_W(8), .IDX_W(10), .CNT_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .s(sifb.slave), .frame_data(fdb), .nn_start(stb),
        .nn_done(dnb), .busy(bzb), .err_short(esb), .err_long(elb), .frame_count(fcb)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        dn;
        logic        rdy;
        logic        st;
        logic        bz;
        logic        es;
        logic        el;
        logic [15:0] cnt;
        logic [31:0] fr;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  golden [BIG];
    int          exp_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic dn,
                       input logic rdy, input logic st, input logic bz, input logic es,
                       input logic el, input logic [15:0] cnt, input logic [31:0] fr);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.dn = dn; r.rdy = rdy; r.st = st; r.bz = bz;
        r.es = es; r.el = el; r.cnt = cnt; r.fr = fr;
        tbl.push_back(r);
    endtask

    task automatic chk_frame_big(input string nm);
        int bad_i = -1;
        for (int i = BIG - 1; i >= 0; i--) begin
            if (fdb[i*8 +: 8] !== golden[i]) bad_i = i;
        end
        n_vec++;
        if (bad_i >= 0) begin
            n_bad++;
            $display("FAIL %s: pixel %0d got %h expected %h", nm, bad_i,
                     fdb[bad_i*8 +: 8], golden[bad_i]);
        end
    endtask

    // One beat on the big stream with random idle gaps and spurious nn_done
    task automatic big_beat(input logic [7:0] d, input logic l);
        int guard = 0;
        while ($urandom_range(1, 0) == 1) begin
            sifb.s_valid = 1'b0;
            dnb = ($urandom_range(7, 0) == 0);
            @(negedge clk);
        end
        dnb = 1'b0;
        sifb.s_valid = 1'b1;
        sifb.s_data  = d;
        sifb.s_last  = l;
        while (!sifb.s_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("beat_timeout", 64'(guard), 64'd0);
        @(negedge clk);
        sifb.s_valid = 1'b0;
        sifb.s_last  = 1'b0;
    endtask

    task automatic big_fill(input string nm);
        for (int i = 0; i < BIG; i++) golden[i] = 8'($urandom);
        for (int i = 0; i < BIG; i++) big_beat(golden[i], (i == BIG - 1));
        chk({nm, "_start"}, {62'd0, stb, sifb.s_ready}, {62'd0, 1'b1, 1'b0});
        chk({nm, "_cnt_held"}, 64'(fcb), 64'(exp_cnt));
        chk_frame_big({nm, "_frame"});
    endtask

    task automatic big_finish(input string nm);
        int k = $urandom_range(6, 1);
        for (int i = 0; i < k; i++) @(negedge clk);
        chk({nm, "_wait"}, {61'd0, sifb.s_ready, stb, bzb}, {61'd0, 1'b0, 1'b0, 1'b1});
        chk_frame_big({nm, "_held"});
        dnb = 1'b1;
        @(negedge clk);
        dnb = 1'b0;
        exp_cnt = (exp_cnt + 1) % 65536;
        chk({nm, "_done"}, {46'd0, sifb.s_ready, bzb, fcb}, {46'd0, 1'b1, 1'b0, 16'(exp_cnt)});
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_small"}, {43'd0, sif4.s_ready, st4, bz4, es4, el4, fc4},
            {43'd0, 5'b00000, 16'd0});
        chk({nm, "_small_fr"}, 64'(fd4), 64'd0);
        chk({nm, "_big"}, {43'd0, sifb.s_ready, stb, bzb, esb, elb, fcb},
            {43'd0, 5'b00000, 16'd0});
        n_vec++;
        if (fdb !== '0) begin
            n_bad++;
            $display("FAIL %s_big_fr: got nonzero frame expected all zero", nm);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        sif4.s_valid = 1'b0; sif4.s_data = 8'h00; sif4.s_last = 1'b0; dn4 = 1'b0;
        sifb.s_valid = 1'b0; sifb.s_data = 8'h00; sifb.s_last = 1'b0; dnb = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset_async");
        repeat (2) @(negedge clk);
        chk_reset_vals("reset_held");
        rst_n = 1'b1;
        #1 chk("ready_before_edge", 64'(sif4.s_ready), 64'd0);
        @(posedge clk);
        #1 chk("ready_after_release", {62'd0, sif4.s_ready, sifb.s_ready}, 64'd3);

        // v d l dn | rdy st bz es el cnt frame
        add(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'h00000011);
        add(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'h00002211);
        add(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'h00332211);
        add(1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 32'h44332211);
        for (int i = 0; i < 5; i++)
            add(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'h44332211);
        add(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 32'h44332211);
        add(1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h443322A0);
        add(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h4433A1A0);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'h44A2A1A0);
        add(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 32'hA3A2A1A0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1, 32'hA3A2A1A0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hA3A2A1A0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hA3A2A1A0);
        // short frame
        add(1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hA3A2A1B0);
        add(1'b1, 8'hB1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 32'hA3A2B1B0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 32'hA3A2B1B0);
        add(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hA3A2B1C0);
        add(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hA3A2C1C0);
        add(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hA3C2C1C0);
        add(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 32'hC3C2C1C0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2, 32'hC3C2C1C0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        // long frame: first four beats repeat the held frame, extra beats differ
        add(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hC2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hD5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hD6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 32'hC3C2C1C0);
        add(1'b1, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3C2C1E0);
        add(1'b1, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3C2E1E0);
        add(1'b1, 8'hE2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hC3E2E1E0);
        add(1'b1, 8'hE3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 32'hE3E2E1E0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 32'hE3E2E1E0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4, 32'hE3E2E1E0);

        foreach (tbl[i]) begin
            @(negedge clk);
            sif4.s_valid = tbl[i].v;
            sif4.s_data  = tbl[i].d;
            sif4.s_last  = tbl[i].l;
            dn4          = tbl[i].dn;
            @(posedge clk);
            #1 chk($sformatf("row%0d", i),
                   {11'd0, sif4.s_ready, st4, bz4, es4, el4, fc4, fd4},
                   {11'd0, tbl[i].rdy, tbl[i].st, tbl[i].bz, tbl[i].es, tbl[i].el,
                    tbl[i].cnt, tbl[i].fr});
        end
        @(negedge clk);
        sif4.s_valid = 1'b0; sif4.s_last = 1'b0; dn4 = 1'b0;

        // three gapped full-size frames
        for (int f = 0; f < 3; f++) begin
            big_fill($sformatf("big%0d", f));
            big_finish($sformatf("big%0d", f));
        end
        chk("big_count3", 64'(fcb), 64'd3);

        // reset while waiting for the accelerator
        big_fill("pre_wait_rst");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_in_wait");
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_wait_rst", 64'(sifb.s_ready), 64'd1);

        // reset partway through a frame
        for (int i = 0; i < 300; i++) big_beat(8'($urandom), 1'b0);
        chk("busy_mid_fill", 64'(bzb), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("rst_in_fill");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        big_fill("after_rst");
        big_finish("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/nn_frame_loader.md
Name: nn_frame_loader

Overview:
- Input-side writer for the inference accelerator top.
- Accepts a byte-wide valid/ready pixel stream with an end-of-frame marker.
- Assembles one complete frame of INPUT_SIZE pixels into a register buffer, presents it on the flattened input bus, and pulses the accelerator start.
- Holds the frame stable and back-pressures the stream until the accelerator reports done; malformed frames are discarded and flagged.

Parameters:
- INPUT_SIZE, 784, pixels per frame (28x28 MNIST).
- DATA_W, 8, pixel width in bits.
- IDX_W, 10, write-index width; must satisfy 2^IDX_W >= INPUT_SIZE.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  stream beat valid.
- s_data  in  DATA_W  pixel value.
- s_last  in  1  final beat of the frame; qualified by s_valid.
- s_ready  out  1  loader accepts a beat this cycle.
- frame_data  out  INPUT_SIZE*DATA_W  assembled frame; pixel i occupies bits [i*DATA_W+DATA_W-1 : i*DATA_W].
- nn_start  out  1  one-cycle start pulse to the accelerator.
- nn_done  in  1  accelerator completion pulse.
- busy  out  1  high from the first accepted beat of a frame until nn_done is consumed.
- err_short  out  1  one-cycle pulse: s_last arrived before INPUT_SIZE beats.
- err_long  out  1  one-cycle pulse: INPUT_SIZE beats arrived without s_last.
- frame_count  out  CNT_W  number of frames completed by the accelerator.

Behaviour:
- Handshake: a beat transfers when s_valid && s_ready on a rising clk edge. s_ready depends only on state, never on s_valid.
- Reset (rst_n low, asynchronous):
  - State FILL, wr_idx=0, frame buffer all zero.
  - s_ready=0, nn_start=0, busy=0, err_short=0, err_long=0, frame_count=0.
- s_ready is registered. It rises on the first clk edge after rst_n deasserts.
- States:
  - FILL:
    - s_ready=1. On each beat, write s_data to buffer[wr_idx] and increment wr_idx.
    - Beat with wr_idx==INPUT_SIZE-1 and s_last=1: store the pixel, wr_idx<=0, go to FIRE.
    - Beat with s_last=1 and wr_idx<INPUT_SIZE-1: pulse err_short next cycle, wr_idx<=0, stay in FILL. Partially written buffer contents are don't-care.
    - Beat with wr_idx==INPUT_SIZE-1 and s_last=0: pulse err_long next cycle, wr_idx<=0, go to DRAIN.
  - DRAIN:
    - s_ready=1. Discard beats; the buffer is not written.
    - Beat with s_last=1: go to FILL. No further error pulse.
  - FIRE:
    - s_ready=0. nn_start=1 for exactly this one cycle, then go to WAIT.
  - WAIT:
    - s_ready=0. frame_data held constant.
    - On nn_done=1: frame_count<=frame_count+1 (wraps modulo 2^CNT_W), go to FILL.
- Timing:
  - The last beat is accepted at edge N. nn_start is high during cycle N+1. s_ready is low from edge N until the edge that samples nn_done.
  - s_ready returns high in the cycle after nn_done is sampled.
  - Minimum frame-to-frame gap is therefore 2 cycles plus accelerator latency.
- nn_done in FILL, DRAIN or FIRE: ignored; no count change.
- busy: 1 in WAIT and FIRE, and in FILL when wr_idx!=0. 0 otherwise.
- frame_data is a direct view of the buffer; consumers may sample it only between nn_start and nn_done.
- Reset mid-frame or mid-WAIT:
  - Immediate return to reset values; any pending nn_start is suppressed.
  - The accelerator is reset by the same rst_n.
- INPUT_SIZE=1: the first beat must carry s_last=1, otherwise err_long is flagged.

Decomposition:
- Shared package nn_pkg:
  - Loader state encoding (FILL, DRAIN, FIRE, WAIT).
  - Network size constants INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE.
  - PIXEL_W=8.
- One sub-module, nn_frame_buffer: INPUT_SIZE x DATA_W register file with a single indexed write port and a fully parallel flattened read port. The FSM, counters and error logic stay in nn_frame_loader.

Test Plan:
- INPUT_SIZE=4; send 0x11,0x22,0x33,0x44 (last on 4th), continuous valid -> frame_data=0x44332211; nn_start high exactly 1 cycle after the 4th beat; s_ready=0 until nn_done.
- Assert nn_done 5 cycles after nn_start -> frame_count 0->1; s_ready=1 the next cycle; a second frame 0xA0..0xA3 loads correctly.
- INPUT_SIZE=4; send 2 beats with last on the 2nd -> err_short single pulse, no nn_start; next correct 4-beat frame starts at index 0.
- INPUT_SIZE=4; send 6 beats with last on the 6th -> err_long pulse after beat 4, beats 5-6 discarded, no nn_start, buffer retains its prior contents.
- Random s_valid gaps (50% duty) over 3 default-size 784-pixel frames -> each frame_data matches the golden image; frame_count=3; spurious nn_done during FILL has no effect.
- rst_n asserted during WAIT and during FILL beat 300 -> all outputs return to reset values asynchronously; after release the first frame loads from index 0.
